// File: rtl/axil_crossbar_addr_ot.sv
// AXI4-lite crossbar address decoder with multi-outstanding admission control.
// Transactions to the same destination stream back-to-back; a destination change drains first.
module axil_crossbar_addr_ot #(
   parameter int S          = 0,
   parameter int S_COUNT    = 4,
   parameter int M_COUNT    = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int M_REGIONS  = 1,
   parameter logic [M_COUNT*M_REGIONS*ADDR_WIDTH-1:0] M_BASE_ADDR = '0,
   parameter logic [M_COUNT*M_REGIONS*32-1:0] M_ADDR_WIDTH = {M_COUNT{{M_REGIONS{32'd24}}}},
   parameter logic [M_COUNT*S_COUNT-1:0] M_CONNECT = {M_COUNT*S_COUNT{1'b1}},
   parameter logic [M_COUNT-1:0] M_SECURE = '0,
   parameter int S_ISSUE    = 4,
   parameter int WC_OUTPUT  = 0,
   parameter int CL_M_COUNT = (M_COUNT > 1) ? $clog2(M_COUNT) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] s_axil_aaddr,
   input  logic [2:0]            s_axil_aprot,
   input  logic                  s_axil_avalid,
   output logic                  s_axil_aready,
   output logic [CL_M_COUNT-1:0] m_select,
   output logic                  m_axil_avalid,
   input  logic                  m_axil_aready,
   output logic [CL_M_COUNT-1:0] m_wc_select,
   output logic                  m_wc_decerr,
   output logic                  m_wc_valid,
   input  logic                  m_wc_ready,
   output logic [CL_M_COUNT-1:0] m_rc_select,
   output logic                  m_rc_decerr,
   output logic                  m_rc_valid,
   input  logic                  m_rc_ready,
   input  logic                  s_cpl_valid
);

   localparam int NR = M_COUNT * M_REGIONS;
   localparam int CW = $clog2(S_ISSUE + 1);
   localparam logic [CW-1:0] ISSUE_MAX = CW'(S_ISSUE);

   // Default map: regions packed in order, each base rounded up to its own size.
   function automatic logic [NR*ADDR_WIDTH-1:0] calc_base_addrs();
      logic [NR*ADDR_WIDTH-1:0] result;
      logic [ADDR_WIDTH:0]      base;
      logic [ADDR_WIDTH:0]      size;
      logic [ADDR_WIDTH:0]      one;
      logic [31:0]              w;
      result = '0;
      base   = '0;
      one    = {{ADDR_WIDTH{1'b0}}, 1'b1};
      for (int i = 0; i < NR; i++) begin
         w = M_ADDR_WIDTH[i*32 +: 32];
         if (w != 32'd0) begin
            size = one << w;
            base = (base + size - one) & ~(size - one);
            result[i*ADDR_WIDTH +: ADDR_WIDTH] = base[ADDR_WIDTH-1:0];
            base = base + size;
         end
      end
      return result;
   endfunction

   localparam logic [NR*ADDR_WIDTH-1:0] BASE_ADDRS =
      (M_BASE_ADDR == '0) ? calc_base_addrs() : M_BASE_ADDR;

   logic [CL_M_COUNT-1:0] r_select;
   logic                  r_decerr;
   logic                  r_av_valid;
   logic                  r_rc_valid;
   logic                  r_wc_valid;
   logic [CW-1:0]         r_count;

   logic [CL_M_COUNT-1:0] w_sel;
   logic                  w_hit;
   logic                  w_decerr;
   logic [31:0]           w_rw;
   logic                  w_cpl_eff;
   logic [CW-1:0]         w_cnt_eff;
   logic                  w_same;
   logic                  w_slots_free;
   logic                  w_accept;
   logic                  w_unused;

   assign w_unused = ^{s_axil_aprot[2], s_axil_aprot[0]};

   // Ascending scan so the highest matching master index wins.
   always_comb begin
      w_hit = 1'b0;
      w_sel = r_select;
      w_rw  = '0;
      for (int i = 0; i < M_COUNT; i++) begin
         for (int j = 0; j < M_REGIONS; j++) begin
            w_rw = M_ADDR_WIDTH[(i*M_REGIONS+j)*32 +: 32];
            if (w_rw != 32'd0 && M_CONNECT[S+i*S_COUNT] &&
                !(M_SECURE[i] && s_axil_aprot[1]) &&
                ((s_axil_aaddr >> w_rw) ==
                 (BASE_ADDRS[(i*M_REGIONS+j)*ADDR_WIDTH +: ADDR_WIDTH] >> w_rw))) begin
               w_hit = 1'b1;
               w_sel = CL_M_COUNT'(i);
            end
         end
      end
   end

   assign w_decerr = !w_hit;

   // A completion this cycle frees its slot for an accept in the same cycle.
   assign w_cpl_eff = s_cpl_valid && (r_count != '0);
   assign w_cnt_eff = r_count - CW'(w_cpl_eff);
   assign w_same    = (w_cnt_eff == '0) || (w_sel == r_select && w_decerr == r_decerr);

   assign w_slots_free = (!r_av_valid || m_axil_aready) &&
                         (!r_rc_valid || m_rc_ready) &&
                         (WC_OUTPUT == 0 || !r_wc_valid || m_wc_ready);

   assign w_accept = s_axil_avalid && !rst && (w_cnt_eff < ISSUE_MAX) && w_slots_free && w_same;

   assign s_axil_aready = w_accept;

   // NOTE: state uses non-blocking assignments and an asynchronous reset, so every
   // register reads its pre-edge value and clears the moment rst rises.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_select   <= '0;
         r_decerr   <= 1'b0;
         r_av_valid <= 1'b0;
         r_rc_valid <= 1'b0;
         r_wc_valid <= 1'b0;
         r_count    <= '0;
      end else begin
         r_count <= r_count + CW'(w_accept) - CW'(w_cpl_eff);
         if (w_accept) begin
            r_select   <= w_sel;
            r_decerr   <= w_decerr;
            r_av_valid <= !w_decerr;
            r_rc_valid <= 1'b1;
            r_wc_valid <= (WC_OUTPUT != 0);
         end else begin
            if (m_axil_aready) r_av_valid <= 1'b0;
            if (m_rc_ready)    r_rc_valid <= 1'b0;
            if (m_wc_ready)    r_wc_valid <= 1'b0;
         end
      end
   end

   assign m_select      = r_select;
   assign m_axil_avalid = r_av_valid;
   assign m_rc_valid    = r_rc_valid;
   assign m_rc_select   = r_select;
   assign m_rc_decerr   = r_decerr;
   assign m_wc_valid    = r_wc_valid;
   assign m_wc_select   = r_select;
   assign m_wc_decerr   = r_decerr;

endmodule

// File: doc/axil_crossbar_addr_ot.md
# axil_crossbar_addr_ot

AXI4-lite crossbar per-slave-port address decoder with multi-outstanding admission control. It decodes each incoming AW/AR address to a master interface index and tracks up to S_ISSUE in-flight transactions. Transactions to the same destination issue back-to-back, one per cycle. A change of destination, or of decode-error status, waits until all outstanding transactions on this port complete. One instance sits on each slave port of the AXI-lite crossbar, once for the write path and once for the read path.

## Interface
- S, 0, slave interface index of this instance
- S_COUNT, 4, number of crossbar slave interfaces
- M_COUNT, 4, number of crossbar master interfaces
- ADDR_WIDTH, 32, address width in bits
- M_REGIONS, 1, address regions per master interface
- M_BASE_ADDR, 0, M_COUNT×M_REGIONS×ADDR_WIDTH region bases; 0 selects packed default bases in order, each aligned to its size
- M_ADDR_WIDTH, {M_COUNT{{M_REGIONS{32'd24}}}}, 32-bit width per region; 0 disables the region
- M_CONNECT, all ones, M_COUNT×S_COUNT connectivity bits; bit S+i*S_COUNT permits master i
- M_SECURE, 0, per-master bit; when set, prot[1]=1 accesses decode as errors
- S_ISSUE, 4, maximum outstanding transactions (1..32)
- WC_OUTPUT, 0, enables the write-command channel
- CL_M_COUNT, derived as max(1, $clog2(M_COUNT)); do not override
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- s_axil_aaddr  in  ADDR_WIDTH  request address
- s_axil_aprot  in  3  request protection bits
- s_axil_avalid  in  1  request valid
- s_axil_aready  out  1  request accepted
- m_select  out  CL_M_COUNT  decoded master index
- m_axil_avalid  out  1  address forward valid; asserted only for decoded, non-error requests
- m_axil_aready  in  1  address forward ready
- m_wc_select / m_wc_decerr / m_wc_valid  out  CL_M_COUNT/1/1  write command
- m_wc_ready  in  1  write command ready
- m_rc_select / m_rc_decerr / m_rc_valid  out  CL_M_COUNT/1/1  reply command
- m_rc_ready  in  1  reply command ready
- s_cpl_valid  in  1  one transaction fully completed on this port (single-cycle pulse)

## Operation
- Decode is combinational on s_axil_aaddr and s_axil_aprot.
- A region hits when all of the following hold:
  - region width is nonzero;
  - the M_CONNECT bit for this port and master is set;
  - secure check passes;
  - addr >> width == base >> width.
- If several regions hit, the highest master index wins. No hit gives decerr=1 and select equal to the last registered value.
- An output slot is "free" when its valid is 0 or its ready is 1 this cycle.
- Admit condition, all required:
  - s_axil_avalid;
  - count < S_ISSUE;
  - AV slot free; RC slot free; WC slot free, or WC_OUTPUT=0;
  - count==0, or (decoded select, decerr) equals the registered (m_select, decerr).
- Blocking on a destination change prevents response reordering across masters.
- Accept action: s_axil_aready=1 combinationally, in the same cycle as the admit. On the next edge:
  - m_select and decerr are loaded;
  - m_axil_avalid is set to !decerr;
  - m_rc_valid is set to 1;
  - m_wc_valid is set to WC_OUTPUT.
- Each valid clears on its own handshake; the three channels drain independently.
- Outstanding counter, $clog2(S_ISSUE+1) bits:
  - +1 on accept, −1 on s_cpl_valid;
  - both in the same cycle leaves it unchanged;
  - s_cpl_valid at count==0 is ignored; the counter never underflows.
- m_wc_select and m_rc_select equal m_select; m_wc_decerr and m_rc_decerr equal the registered decerr.

## Timing
- Reset values:
  - s_axil_aready 0;
  - all valids 0;
  - m_select 0; decerr 0; counter 0.
- Reset assertion clears state immediately (asynchronously). Outstanding transactions are discarded on reset.
- Accept-to-output latency is 1 cycle.
- Sustained throughput is 1 transaction/cycle when the target is the same, downstream readies are held high, and count < S_ISSUE.
- Destination switch: the earliest accept is in the cycle where count==1 and s_cpl_valid=1, i.e. zero bubble beyond the completion.
- At count==S_ISSUE, a completion in cycle t allows an accept in the same cycle t.
- s_axil_aready is never asserted without s_axil_avalid, and never during reset.
- Registered outputs hold stable while valid && !ready.

## Test plan
- Default config, S_ISSUE=4, readies high: 6 back-to-back requests to 0x0100_0000 -> first 4 accepted on consecutive cycles, m_select=1, then aready=0; pulsing s_cpl_valid twice admits 2 more.
- Request 0x0000_0010, then 0x0200_0000 with no completion -> second stalls; s_cpl_valid asserted -> accepted in that same cycle; next cycle m_select=2.
- Address 0x0500_0000 (unmapped) -> m_rc_valid=1, m_rc_decerr=1, m_axil_avalid stays 0, counter increments; a following valid address to 0x0 waits for its completion.
- M_SECURE=4'b0010, prot=3'b010 to 0x0100_0000 -> decerr=1; same address with prot=3'b000 -> m_select=1, decerr=0.
- WC_OUTPUT=1, m_wc_ready held low for 3 cycles, other readies high -> m_axil_avalid and m_rc_valid clear after 1 cycle, m_wc_valid holds; next accept blocked until m_wc_ready=1.
- Counter at 3, rst pulsed mid-cycle -> all outputs 0 immediately; after release, 4 fresh accepts permitted.
